// File: rtl/cache_repl_pkg.sv
// Shared types and helpers for the DIP replacement engine: policy modes,
// set-dueling roles and the leader-set classifier.
package cache_repl_pkg;

  typedef enum logic [1:0] {
    REPL_LRU,
    REPL_BIP,
    REPL_DIP
  } repl_mode_e;

  typedef enum logic [1:0] {
    FOLLOWER,
    LRU_LEADER,
    BIP_LEADER
  } set_type_e;

  // Leaders are picked by comparing the upper and lower K index bits:
  // equal -> LRU leader, bitwise complement -> BIP leader.
  function automatic set_type_e classify_set(input int unsigned idx,
                                             input int unsigned index_width);
    int unsigned k;
    int unsigned mask;
    int unsigned hi;
    int unsigned lo;
    k    = index_width / 2;
    mask = (32'd1 << k) - 32'd1;
    hi   = (idx >> (index_width - k)) & mask;
    lo   = idx & mask;
    if (hi == lo) return LRU_LEADER;
    if (hi == (~lo & mask)) return BIP_LEADER;
    return FOLLOWER;
  endfunction

endpackage

// File: rtl/dip_psel_ctr.sv
// Set-dueling control: classifies leader sets, keeps the saturating PSEL
// counter and the BIP throttle counter, and tells the top whether a fill touches.
module dip_psel_ctr
  import cache_repl_pkg::*;
#(
  parameter int         INDEX_WIDTH  = 5,
  parameter int         PSEL_WIDTH   = 10,
  parameter int         BIP_EPS_LOG2 = 5,
  parameter repl_mode_e MODE         = REPL_DIP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   access_valid,
  input  logic                   access_hit,
  input  logic [INDEX_WIDTH-1:0] access_index,
  input  logic                   fill_valid,
  input  logic [INDEX_WIDTH-1:0] fill_index,
  output logic [PSEL_WIDTH-1:0]  psel,
  output logic                   policy_bip,
  output logic                   fill_touch
);

  localparam logic [PSEL_WIDTH-1:0] PSEL_INIT = {1'b0, {(PSEL_WIDTH-1){1'b1}}};

  logic [PSEL_WIDTH-1:0]   psel_reg;
  logic [BIP_EPS_LOG2-1:0] bip_ctr_reg;
  set_type_e               access_type;
  set_type_e               fill_type;
  logic                    follower_bip;
  logic                    fill_bip;

  always_comb begin
    access_type  = classify_set(32'(access_index), 32'(INDEX_WIDTH));
    fill_type    = classify_set(32'(fill_index), 32'(INDEX_WIDTH));
    follower_bip = psel_reg[PSEL_WIDTH-1];
    fill_bip     = 1'b0;
    policy_bip   = 1'b0;
    case (MODE)
      REPL_LRU: begin
        fill_bip   = 1'b0;
        policy_bip = 1'b0;
      end
      REPL_BIP: begin
        fill_bip   = 1'b1;
        policy_bip = 1'b1;
      end
      default: begin
        fill_bip   = (fill_type == BIP_LEADER) ||
                     ((fill_type == FOLLOWER) && follower_bip);
        policy_bip = follower_bip;
      end
    endcase
    // BIP only promotes to MRU once per 2**BIP_EPS_LOG2 of its fills
    fill_touch = !fill_bip || (bip_ctr_reg == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_reg    <= PSEL_INIT;
      bip_ctr_reg <= '0;
    end else begin
      if (MODE == REPL_DIP && access_valid && !access_hit) begin
        if (access_type == LRU_LEADER && psel_reg != '1)
          psel_reg <= psel_reg + 1'b1;
        else if (access_type == BIP_LEADER && psel_reg != '0)
          psel_reg <= psel_reg - 1'b1;
      end
      if (fill_valid && fill_bip)
        bip_ctr_reg <= bip_ctr_reg + 1'b1;
    end
  end

  assign psel = psel_reg;

endmodule

// File: rtl/cache_repl_dip.sv
// N-way tree pseudo-LRU replacement with Dynamic Insertion Policy.
// Holds per-set tree bits; victim selection is a combinational read of registered state.
module cache_repl_dip
  import cache_repl_pkg::*;
#(
  parameter int         INDEX_WIDTH   = 5,
  parameter int         ASSOCIATIVITY = 4,
  parameter int         PSEL_WIDTH    = 10,
  parameter int         BIP_EPS_LOG2  = 5,
  parameter repl_mode_e MODE          = REPL_DIP,
  localparam int        WAY_W         = $clog2(ASSOCIATIVITY)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     access_valid,
  input  logic [INDEX_WIDTH-1:0]   access_index,
  input  logic                     access_hit,
  input  logic [WAY_W-1:0]         access_way,
  input  logic                     fill_valid,
  input  logic [INDEX_WIDTH-1:0]   fill_index,
  input  logic [WAY_W-1:0]         fill_way,
  input  logic [INDEX_WIDTH-1:0]   victim_index,
  input  logic [ASSOCIATIVITY-1:0] victim_valid_mask,
  output logic [WAY_W-1:0]         victim_way,
  output logic                     policy_bip,
  output logic [PSEL_WIDTH-1:0]    psel
);

  localparam int DEPTH  = 2 ** INDEX_WIDTH;
  localparam int TREE_W = ASSOCIATIVITY - 1;

  typedef logic [TREE_W-1:0] tree_t;

  // Heap-ordered nodes: node n has children 2n+1 (lower) and 2n+2 (upper).
  // The tree is padded by one bit so the node index is exactly WAY_W wide.
  function automatic tree_t tree_touch(input tree_t t, input logic [WAY_W-1:0] w);
    logic [ASSOCIATIVITY-1:0] ext;
    logic [WAY_W-1:0]         node;
    logic [WAY_W-1:0]         rem;
    logic                     b;
    ext  = {1'b0, t};
    node = '0;
    rem  = w;
    for (int l = 0; l < WAY_W; l++) begin
      b         = rem[WAY_W-1];
      ext[node] = ~b;
      node      = WAY_W'(2 * int'(node) + 1 + int'(b));
      rem       = rem << 1;
    end
    return ext[TREE_W-1:0];
  endfunction

  function automatic logic [WAY_W-1:0] tree_victim(input tree_t t);
    logic [ASSOCIATIVITY-1:0] ext;
    logic [WAY_W-1:0]         node;
    logic [WAY_W-1:0]         w;
    logic                     b;
    ext  = {1'b0, t};
    node = '0;
    w    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = ext[node];
      w    = WAY_W'({w, b});
      node = WAY_W'(2 * int'(node) + 1 + int'(b));
    end
    return w;
  endfunction

  tree_t tree_reg [DEPTH];
  tree_t hit_tree;
  tree_t fill_base;
  tree_t fill_tree;
  logic  hit_en;
  logic  fill_touch;

  dip_psel_ctr #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .PSEL_WIDTH  (PSEL_WIDTH),
    .BIP_EPS_LOG2(BIP_EPS_LOG2),
    .MODE        (MODE)
  ) u_psel (
    .clk         (clk),
    .rst         (rst),
    .access_valid(access_valid),
    .access_hit  (access_hit),
    .access_index(access_index),
    .fill_valid  (fill_valid),
    .fill_index  (fill_index),
    .psel        (psel),
    .policy_bip  (policy_bip),
    .fill_touch  (fill_touch)
  );

  assign hit_en = access_valid && access_hit;

  // A hit and a fill to the same set chain: the fill update starts from the touched tree.
  always_comb begin
    hit_tree  = tree_touch(tree_reg[access_index], access_way);
    fill_base = (hit_en && access_index == fill_index) ? hit_tree : tree_reg[fill_index];
    fill_tree = fill_touch ? tree_touch(fill_base, fill_way) : fill_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        tree_reg[i] <= '0;
    end else begin
      if (hit_en)
        tree_reg[access_index] <= hit_tree;
      if (fill_valid)
        tree_reg[fill_index] <= fill_tree;
    end
  end

  // Invalid ways are always filled first, lowest index wins.
  always_comb begin
    victim_way = tree_victim(tree_reg[victim_index]);
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--)
      if (!victim_valid_mask[i])
        victim_way = WAY_W'(i);
  end

endmodule

// File: tb/tb_cache_repl_dip.sv
// Drives LRU, BIP and DIP instances with shared stimulus and checks each
// against a behavioural replacement model.
module tb_cache_repl_dip;
  import cache_repl_pkg::*;

  localparam int IW   = 5;
  localparam int A    = 4;
  localparam int PW   = 10;
  localparam int EPS  = 5;
  localparam int NSET = 32;
  localparam int NM   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       access_valid, access_hit, fill_valid;
  logic [4:0] access_index, fill_index, victim_index;
  logic [1:0] access_way, fill_way;
  logic [3:0] victim_valid_mask;
  logic [1:0] vw [NM];
  logic [9:0] ps [NM];
  logic       pb [NM];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NM; gi++) begin : g_dut
    cache_repl_dip #(
      .INDEX_WIDTH  (IW),
      .ASSOCIATIVITY(A),
      .PSEL_WIDTH   (PW),
      .BIP_EPS_LOG2 (EPS),
      .MODE         (repl_mode_e'(gi))
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .access_valid     (access_valid),
      .access_index     (access_index),
      .access_hit       (access_hit),
      .access_way       (access_way),
      .fill_valid       (fill_valid),
      .fill_index       (fill_index),
      .fill_way         (fill_way),
      .victim_index     (victim_index),
      .victim_valid_mask(victim_valid_mask),
      .victim_way       (vw[gi]),
      .policy_bip       (pb[gi]),
      .psel             (ps[gi])
    );
  end

  // Model: 1-based heap of node bits per set (children 2n lower, 2n+1 upper).
  int m_tree [NM][NSET][A];
  int m_psel [NM];
  int m_ctr  [NM];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int m = 0; m < NM; m++) begin
      for (int s = 0; s < NSET; s++)
        for (int n = 0; n < A; n++)
          m_tree[m][s][n] = 0;
      m_psel[m] = (1 << (PW - 1)) - 1;
      m_ctr[m]  = 0;
    end
  endtask

  // 1 = LRU leader, 2 = BIP leader, 0 = follower
  function automatic int set_kind(input int idx);
    int k, hi, lo;
    k  = IW / 2;
    hi = (idx >> (IW - k)) % (1 << k);
    lo = idx % (1 << k);
    if (hi == lo) return 1;
    if (hi == (1 << k) - 1 - lo) return 2;
    return 0;
  endfunction

  function automatic int m_policy(input int m);
    if (m == 0) return 0;
    if (m == 1) return 1;
    return (m_psel[m] >= (1 << (PW - 1))) ? 1 : 0;
  endfunction

  function automatic int m_victim(input int m, input int s, input int mask);
    int node, lo, size;
    for (int w = 0; w < A; w++)
      if (((mask >> w) & 1) == 0) return w;
    node = 1; lo = 0; size = A;
    while (size > 1) begin
      size = size / 2;
      if (m_tree[m][s][node] == 1) begin
        lo   = lo + size;
        node = 2 * node + 1;
      end else begin
        node = 2 * node;
      end
    end
    return lo;
  endfunction

  task automatic m_touch(input int m, input int s, input int w);
    int node, lo, size;
    node = 1; lo = 0; size = A;
    while (size > 1) begin
      size = size / 2;
      if (w >= lo + size) begin
        m_tree[m][s][node] = 0;
        lo   = lo + size;
        node = 2 * node + 1;
      end else begin
        m_tree[m][s][node] = 1;
        node = 2 * node;
      end
    end
  endtask

  task automatic m_edge();
    int follow, kind, bip;
    for (int m = 0; m < NM; m++) begin
      follow = m_policy(m);
      if (access_valid && access_hit)
        m_touch(m, int'(access_index), int'(access_way));
      if (fill_valid) begin
        kind = set_kind(int'(fill_index));
        if (m == 0) bip = 0;
        else if (m == 1) bip = 1;
        else if (kind == 1) bip = 0;
        else if (kind == 2) bip = 1;
        else bip = follow;
        if (bip == 0 || m_ctr[m] == 0)
          m_touch(m, int'(fill_index), int'(fill_way));
        if (bip == 1)
          m_ctr[m] = (m_ctr[m] + 1) % (1 << EPS);
      end
      if (m == 2 && access_valid && !access_hit) begin
        kind = set_kind(int'(access_index));
        if (kind == 1 && m_psel[m] < (1 << PW) - 1) m_psel[m]++;
        else if (kind == 2 && m_psel[m] > 0) m_psel[m]--;
      end
    end
  endtask

  task automatic drive(input int av, input int ah, input int ai, input int aw,
                       input int fv, input int fi, input int fw,
                       input int vi, input int mask);
    access_valid      = 1'(av);
    access_hit        = 1'(ah);
    access_index      = 5'(ai);
    access_way        = 2'(aw);
    fill_valid        = 1'(fv);
    fill_index        = 5'(fi);
    fill_way          = 2'(fw);
    victim_index      = 5'(vi);
    victim_valid_mask = 4'(mask);
  endtask

  task automatic check_outputs(input string tag);
    for (int m = 0; m < NM; m++) begin
      check_val($sformatf("%s/victim%0d", tag, m), 32'(vw[m]),
                32'(m_victim(m, int'(victim_index), int'(victim_valid_mask))));
      check_val($sformatf("%s/psel%0d", tag, m), 32'(ps[m]), 32'(m_psel[m]));
      check_val($sformatf("%s/policy%0d", tag, m), 32'(pb[m]), 32'(m_policy(m)));
    end
  endtask

  // Inputs must already be driven; checks pre-edge outputs, clocks, updates the model.
  task automatic cycle(input string tag, input bit verbose);
    #2;
    check_outputs(tag);
    if (verbose)
      $display("[TB] %s acc=%0d/%0d set=%0d way=%0d fill=%0d set=%0d way=%0d q=%0d mask=%h victim=%0d/%0d/%0d psel=%0d",
               tag, access_valid, access_hit, access_index, access_way, fill_valid,
               fill_index, fill_way, victim_index, victim_valid_mask, vw[0], vw[1], vw[2], ps[2]);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic probe(input int vi, input int mask);
    drive(0, 0, 0, 0, 0, 0, 0, vi, mask);
    #1;
  endtask

  // Asynchronous pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 15);
    rst = 1'b1;
    m_reset();
    #12;

    // Reset state across all sets
    for (int s = 0; s < NSET; s++) begin
      victim_index = 5'(s);
      #1;
      for (int m = 0; m < NM; m++)
        check_val($sformatf("reset/victim%0d_set%0d", m, s), 32'(vw[m]), 32'd0);
    end
    for (int m = 0; m < NM; m++) begin
      check_val($sformatf("reset/psel%0d", m), 32'(ps[m]), 32'd511);
      check_val($sformatf("reset/policy%0d", m), 32'(pb[m]), (m == 1) ? 32'd1 : 32'd0);
    end
    $display("[TB] reset state checked");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LRU tree walk: hits on set 5
    for (int w = 0; w < A; w++) begin
      drive(1, 1, 5, w, 0, 0, 0, 5, 15);
      cycle($sformatf("lru_hit_w%0d", w), 1'b1);
    end
    probe(5, 15);
    check_val("lru_after_4hits", 32'(vw[0]), 32'd0);
    drive(1, 1, 5, 0, 0, 0, 0, 5, 15);
    cycle("lru_hit_w0_again", 1'b1);
    probe(5, 15);
    check_val("lru_after_hit0", 32'(vw[0]), 32'd2);

    // BIP throttled insertion on set 3
    do_reset();
    drive(0, 0, 0, 0, 1, 3, 0, 3, 15);
    cycle("bip_fill1", 1'b1);
    probe(3, 15);
    check_val("bip_fill1_victim", 32'(vw[1]), 32'd2);
    drive(0, 0, 0, 0, 1, 3, 2, 3, 15);
    cycle("bip_fill2", 1'b1);
    probe(3, 15);
    check_val("bip_fill2_victim", 32'(vw[1]), 32'd2);
    for (int i = 3; i <= 32; i++) begin
      drive(0, 0, 0, 0, 1, 3, 2, 3, 15);
      cycle("bip_fill_bulk", 1'b0);
    end
    probe(3, 15);
    check_val("bip_fill32_victim", 32'(vw[1]), 32'd2);
    drive(0, 0, 0, 0, 1, 3, 2, 3, 15);
    cycle("bip_fill33", 1'b1);
    probe(3, 15);
    check_val("bip_fill33_victim", 32'(vw[1]), 32'd1);

    // PSEL dueling
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 1, 15);
      cycle("psel_follower_miss", 1'b0);
    end
    probe(1, 15);
    check_val("psel_follower_held", 32'(ps[2]), 32'd511);
    for (int i = 0; i < 600; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 15);
      cycle("psel_lru_leader_miss", 1'b0);
    end
    probe(0, 15);
    check_val("psel_saturate_high", 32'(ps[2]), 32'd1023);
    check_val("policy_bip_high", 32'(pb[2]), 32'd1);
    $display("[TB] 600 misses to LRU leader: psel=%0d policy_bip=%0d", ps[2], pb[2]);
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 1, 15);
      cycle("psel_follower_miss2", 1'b0);
    end
    probe(1, 15);
    check_val("psel_follower_held_high", 32'(ps[2]), 32'd1023);
    for (int i = 0; i < 2000; i++) begin
      drive(1, 0, 3, 0, 0, 0, 0, 3, 15);
      cycle("psel_bip_leader_miss", 1'b0);
    end
    probe(3, 15);
    check_val("psel_saturate_low", 32'(ps[2]), 32'd0);
    check_val("policy_bip_low", 32'(pb[2]), 32'd0);
    $display("[TB] 2000 misses to BIP leader: psel=%0d policy_bip=%0d", ps[2], pb[2]);

    // Valid mask priority overrides the tree
    probe(5, 4'b1011);
    for (int m = 0; m < NM; m++)
      check_val($sformatf("mask1011_victim%0d", m), 32'(vw[m]), 32'd2);
    probe(5, 15);
    check_outputs("mask1111");

    // Same-set hit and fill in one cycle
    do_reset();
    drive(1, 1, 1, 0, 1, 1, 3, 1, 15);
    cycle("hit_fill_same_set", 1'b1);
    probe(1, 15);
    for (int m = 0; m < NM; m++)
      check_val($sformatf("hit_fill_victim%0d", m), 32'(vw[m]), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NSET - 1),
            $urandom_range(0, A - 1), $urandom_range(0, 1), $urandom_range(0, NSET - 1),
            $urandom_range(0, A - 1), $urandom_range(0, NSET - 1),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 15);
      cycle($sformatf("rand%0d", i), 1'b1);
    end

    // Asynchronous reset in the middle of a cycle
    drive(1, 0, 0, 1, 1, 7, 2, 5, 15);
    #2;
    rst = 1'b1;
    #1;
    for (int m = 0; m < NM; m++) begin
      check_val($sformatf("async_rst/psel%0d", m), 32'(ps[m]), 32'd511);
      check_val($sformatf("async_rst/victim%0d", m), 32'(vw[m]), 32'd0);
    end
    $display("[TB] async reset mid-cycle: psel=%0d victim=%0d/%0d/%0d", ps[2], vw[0], vw[1], vw[2]);
    m_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    m_edge();
    #1;
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NSET - 1),
            $urandom_range(0, A - 1), $urandom_range(0, 1), $urandom_range(0, NSET - 1),
            $urandom_range(0, A - 1), $urandom_range(0, NSET - 1), 15);
      cycle($sformatf("post_rst%0d", i), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
